// File: rtl/training_sample_feeder.sv
// training_sample_feeder
// Sample source for the training controller. Holds a DEPTH-entry table of
// (x1, x2, t) samples, presents one at a time with ready, advances on consume,
// and repeats passes until one is error-free or MAX_EPOCHS passes are done.
//
// Ports:
//   Clk, Rst              clock (rising edge), synchronous active-high reset
//   load_we/addr/x1/x2/t  table write port, honoured only while idle or done
//   start                 begin a training run (idle/done only)
//   consume, match        controller took the sample / prediction was correct
//   x1, x2, t             presented sample (registered)
//   ready                 sample valid and awaiting consume
//   Count                 samples consumed this pass; DEPTH+1 marks end of pass
//   pass_done             one-cycle pulse at end of each pass
//   epoch                 completed passes in the current run
//   err_cnt               mispredictions in the current pass (saturating)
//   done, converged       run finished / last pass had no errors
module training_sample_feeder #(
    parameter int unsigned DW         = 8,
    parameter int unsigned DEPTH      = 200,
    parameter int unsigned MAX_EPOCHS = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load_we,
    input  logic [7:0]    load_addr,
    input  logic [DW-1:0] load_x1,
    input  logic [DW-1:0] load_x2,
    input  logic [DW-1:0] load_t,
    input  logic          start,
    input  logic          consume,
    input  logic          match,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] t,
    output logic          ready,
    output logic [7:0]    Count,
    output logic          pass_done,
    output logic [7:0]    epoch,
    output logic [7:0]    err_cnt,
    output logic          done,
    output logic          converged
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = 3 * DW;

    localparam logic [7:0] DEPTH_B   = 8'(DEPTH);
    localparam logic [7:0] LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [7:0] CNT_END   = 8'(DEPTH + 1);
    localparam logic [7:0] EPOCH_MAX = 8'(MAX_EPOCHS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_PRESENT  = 3'd2;
    localparam logic [2:0] S_END_PASS = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [EW-1:0] mem [DEPTH];

    logic [2:0]    state, state_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [DW-1:0] x1_nxt, x2_nxt, t_nxt;
    logic          ready_nxt;
    logic [7:0]    count_nxt;
    logic          pass_done_nxt;
    logic [7:0]    epoch_nxt;
    logic [7:0]    err_nxt;
    logic          done_nxt;
    logic          converged_nxt;

    logic          quiet;
    logic          table_wr;
    logic [EW-1:0] entry;

    // Table is only writable between runs; out-of-range addresses are dropped.
    assign quiet    = (state == S_IDLE) || (state == S_DONE);
    assign table_wr = load_we && quiet && (load_addr < DEPTH_B);
    assign entry    = mem[AW'(idx)];

    // Table storage, deliberately outside reset so contents survive Rst.
    always_ff @(posedge Clk) begin
        if (table_wr) begin
            mem[AW'(load_addr)] <= {load_x1, load_x2, load_t};
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            idx       <= 8'd0;
            x1        <= '0;
            x2        <= '0;
            t         <= '0;
            ready     <= 1'b0;
            Count     <= 8'd0;
            pass_done <= 1'b0;
            epoch     <= 8'd0;
            err_cnt   <= 8'd0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            x1        <= x1_nxt;
            x2        <= x2_nxt;
            t         <= t_nxt;
            ready     <= ready_nxt;
            Count     <= count_nxt;
            pass_done <= pass_done_nxt;
            epoch     <= epoch_nxt;
            err_cnt   <= err_nxt;
            done      <= done_nxt;
            converged <= converged_nxt;
        end
    end

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so the registered value lines up with the state it belongs to.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        x1_nxt        = x1;
        x2_nxt        = x2;
        t_nxt         = t;
        ready_nxt     = 1'b0;
        count_nxt     = Count;
        pass_done_nxt = 1'b0;
        epoch_nxt     = epoch;
        err_nxt       = err_cnt;
        done_nxt      = done;
        converged_nxt = converged;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_nxt       = 8'd0;
                    count_nxt     = 8'd0;
                    epoch_nxt     = 8'd0;
                    err_nxt       = 8'd0;
                    done_nxt      = 1'b0;
                    converged_nxt = 1'b0;
                    state_nxt     = S_FETCH;
                end
            end

            S_FETCH: begin
                x1_nxt    = entry[EW-1:2*DW];
                x2_nxt    = entry[2*DW-1:DW];
                t_nxt     = entry[DW-1:0];
                ready_nxt = 1'b1;
                state_nxt = S_PRESENT;
            end

            S_PRESENT: begin
                ready_nxt = 1'b1;
                if (consume) begin
                    ready_nxt = 1'b0;
                    if (!match && (err_cnt != 8'hFF)) begin
                        err_nxt = err_cnt + 8'd1;
                    end
                    if (idx == LAST_IDX) begin
                        // Last sample: jump straight to the end-of-pass marker.
                        count_nxt     = CNT_END;
                        pass_done_nxt = 1'b1;
                        epoch_nxt     = epoch + 8'd1;
                        state_nxt     = S_END_PASS;
                    end else begin
                        count_nxt = Count + 8'd1;
                        idx_nxt   = idx + 8'd1;
                        state_nxt = S_FETCH;
                    end
                end
            end

            S_END_PASS: begin
                // epoch already holds the incremented pass count here.
                if ((err_cnt == 8'd0) || (epoch == EPOCH_MAX)) begin
                    done_nxt      = 1'b1;
                    converged_nxt = (err_cnt == 8'd0);
                    state_nxt     = S_DONE;
                end else begin
                    idx_nxt   = 8'd0;
                    count_nxt = 8'd0;
                    err_nxt   = 8'd0;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_training_sample_feeder.sv
// Self-checking bench for training_sample_feeder: a small DEPTH=4 instance for
// the protocol scenarios and a default DEPTH=200 instance for the end marker.
module tb_training_sample_feeder;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       load_we_a = 1'b0;
    logic       load_we_b = 1'b0;
    logic [7:0] load_addr = 8'd0;
    logic [7:0] load_x1 = 8'd0, load_x2 = 8'd0, load_t = 8'd0;
    logic       start_a = 1'b0, consume_a = 1'b0, match_a = 1'b0;
    logic       start_b = 1'b0, consume_b = 1'b0, match_b = 1'b0;

    logic [7:0] x1_a, x2_a, t_a, Count_a, epoch_a, err_cnt_a;
    logic       ready_a, pass_done_a, done_a, converged_a;
    logic [7:0] x1_b, x2_b, t_b, Count_b, epoch_b, err_cnt_b;
    logic       ready_b, pass_done_b, done_b, converged_b;

    int checks = 0;
    int failures = 0;

    logic [23:0] tbl_a [4];
    logic [23:0] tbl_b [200];

    always #5 Clk = ~Clk;

    training_sample_feeder #(.DW(8), .DEPTH(4), .MAX_EPOCHS(3)) dut_a (
        .Clk(Clk), .Rst(Rst), .load_we(load_we_a), .load_addr(load_addr),
        .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
        .start(start_a), .consume(consume_a), .match(match_a),
        .x1(x1_a), .x2(x2_a), .t(t_a), .ready(ready_a), .Count(Count_a),
        .pass_done(pass_done_a), .epoch(epoch_a), .err_cnt(err_cnt_a),
        .done(done_a), .converged(converged_a)
    );

    training_sample_feeder dut_b (
        .Clk(Clk), .Rst(Rst), .load_we(load_we_b), .load_addr(load_addr),
        .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
        .start(start_b), .consume(consume_b), .match(match_b),
        .x1(x1_b), .x2(x2_b), .t(t_b), .ready(ready_b), .Count(Count_b),
        .pass_done(pass_done_b), .epoch(epoch_b), .err_cnt(err_cnt_b),
        .done(done_b), .converged(converged_b)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Advance until the selected instance shows ready; n = cycles waited.
    task automatic wait_ready(input bit which, output int n);
        n = 0;
        while (!(which ? ready_b : ready_a) && n < 20) begin
            step();
            n++;
        end
        if (!(which ? ready_b : ready_a)) begin
            checks++;
            failures++;
            $display("FAIL wait_ready dut=%0d: ready still 0 after %0d cycles", which, n);
        end
    endtask

    task automatic test_reset();
        logic [51:0] obs;
        obs = {ready_a, x1_a, x2_a, t_a, Count_a, pass_done_a, epoch_a, err_cnt_a, done_a, converged_a};
        checks++;
        if (obs !== 52'd0) begin
            failures++;
            $display("FAIL reset_a: outputs=%h required 0", obs);
        end
        obs = {ready_b, x1_b, x2_b, t_b, Count_b, pass_done_b, epoch_b, err_cnt_b, done_b, converged_b};
        checks++;
        if (obs !== 52'd0) begin
            failures++;
            $display("FAIL reset_b: outputs=%h required 0", obs);
        end
    endtask

    task automatic load_a();
        for (int i = 0; i < 4; i++) begin
            tbl_a[i] = 24'($urandom);
            load_we_a = 1'b1;
            load_addr = 8'(i);
            {load_x1, load_x2, load_t} = tbl_a[i];
            step();
        end
        // Address DEPTH must be dropped, not aliased onto entry 0.
        load_addr = 8'd4;
        {load_x1, load_x2, load_t} = ~tbl_a[0];
        step();
        load_we_a = 1'b0;
    endtask

    // One full run on the DEPTH=4/MAX_EPOCHS=3 instance.
    // mode 0: all correct, 1: sample 2 wrong every pass, 2: random matches.
    // poke: pulse consume during FETCH; wr: attempt a table write in PRESENT.
    task automatic run_a(input int mode, input bit poke, input bit wr);
        int ep, err, n, exp_wait, idle;
        bit fin, m;
        logic [23:0] held;
        ep = 0;
        fin = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (ready_a !== 1'b0) begin
            failures++;
            $display("FAIL start_latency_early: ready=%b required 0", ready_a);
        end
        exp_wait = 1;
        while (!fin) begin
            err = 0;
            for (int k = 0; k < 4; k++) begin
                wait_ready(1'b0, n);
                checks++;
                if (n !== exp_wait) begin
                    failures++;
                    $display("FAIL ready_latency pass=%0d k=%0d: waited %0d required %0d", ep, k, n, exp_wait);
                end
                checks++;
                if ({x1_a, x2_a, t_a} !== tbl_a[k]) begin
                    failures++;
                    $display("FAIL sample_data pass=%0d k=%0d: got %h required %h", ep, k, {x1_a, x2_a, t_a}, tbl_a[k]);
                end
                held = {x1_a, x2_a, t_a};
                idle = (k == 0 && ep == 0) ? 5 : int'($urandom_range(0, 2));
                if (wr && idle == 0) idle = 1;
                for (int i = 0; i < idle; i++) begin
                    if (wr && k == 0 && i == 0) begin
                        load_we_a = 1'b1;
                        load_addr = 8'd0;
                        {load_x1, load_x2, load_t} = ~tbl_a[0];
                    end
                    step();
                    load_we_a = 1'b0;
                    checks++;
                    if (ready_a !== 1'b1 || {x1_a, x2_a, t_a} !== held) begin
                        failures++;
                        $display("FAIL hold k=%0d: ready=%b data=%h required 1 %h", k, ready_a, {x1_a, x2_a, t_a}, held);
                    end
                end
                case (mode)
                    0:       m = 1'b1;
                    1:       m = (k != 1);
                    default: m = ($urandom_range(0, 3) != 0);
                endcase
                consume_a = 1'b1;
                match_a = m;
                step();
                consume_a = 1'b0;
                match_a = 1'b0;
                if (!m) err++;
                checks++;
                if (ready_a !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_drop k=%0d: ready=%b required 0", k, ready_a);
                end
                if (k < 3) begin
                    checks++;
                    if (Count_a !== 8'(k + 1) || pass_done_a !== 1'b0) begin
                        failures++;
                        $display("FAIL count k=%0d: Count=%0d pass_done=%b required %0d 0", k, Count_a, pass_done_a, k + 1);
                    end
                    exp_wait = 1;
                    if (poke) begin
                        consume_a = 1'b1;
                        step();
                        consume_a = 1'b0;
                        exp_wait = 0;
                        checks++;
                        if (Count_a !== 8'(k + 1)) begin
                            failures++;
                            $display("FAIL consume_in_fetch k=%0d: Count=%0d required %0d", k, Count_a, k + 1);
                        end
                    end
                end else begin
                    ep++;
                    checks++;
                    if (Count_a !== 8'd5 || pass_done_a !== 1'b1 || epoch_a !== 8'(ep) || err_cnt_a !== 8'(err)) begin
                        failures++;
                        $display("FAIL end_pass %0d: Count=%0d pass_done=%b epoch=%0d err=%0d required 5 1 %0d %0d",
                                 ep, Count_a, pass_done_a, epoch_a, err_cnt_a, ep, err);
                    end
                end
            end
            fin = (err == 0) || (ep == 3);
            step();
            checks++;
            if (pass_done_a !== 1'b0) begin
                failures++;
                $display("FAIL pass_done_width: pass_done=%b required 0", pass_done_a);
            end
            checks++;
            if (fin) begin
                if (done_a !== 1'b1 || converged_a !== (err == 0) || epoch_a !== 8'(ep) || ready_a !== 1'b0) begin
                    failures++;
                    $display("FAIL run_end: done=%b conv=%b epoch=%0d ready=%b required 1 %b %0d 0",
                             done_a, converged_a, epoch_a, ready_a, err == 0, ep);
                end
            end else if (done_a !== 1'b0) begin
                failures++;
                $display("FAIL early_done pass=%0d: done=%b required 0", ep, done_a);
            end
            exp_wait = 1;
        end
    endtask

    task automatic test_rst_mid();
        int n;
        logic [51:0] obs;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_ready(1'b0, n);
            consume_a = 1'b1;
            match_a = 1'b1;
            step();
            consume_a = 1'b0;
            match_a = 1'b0;
        end
        wait_ready(1'b0, n);
        checks++;
        if (Count_a !== 8'd2) begin
            failures++;
            $display("FAIL rst_setup: Count=%0d required 2", Count_a);
        end
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        obs = {ready_a, x1_a, x2_a, t_a, Count_a, pass_done_a, epoch_a, err_cnt_a, done_a, converged_a};
        checks++;
        if (obs !== 52'd0) begin
            failures++;
            $display("FAIL rst_mid_run: outputs=%h required 0", obs);
        end
    endtask

    task automatic test_default_depth();
        int n;
        for (int i = 0; i < 200; i++) begin
            tbl_b[i] = 24'($urandom);
            load_we_b = 1'b1;
            load_addr = 8'(i);
            {load_x1, load_x2, load_t} = tbl_b[i];
            step();
        end
        load_we_b = 1'b0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 200; k++) begin
                wait_ready(1'b1, n);
                checks++;
                if ({x1_b, x2_b, t_b} !== tbl_b[k]) begin
                    failures++;
                    $display("FAIL big_data p=%0d k=%0d: got %h required %h", p, k, {x1_b, x2_b, t_b}, tbl_b[k]);
                end
                consume_b = 1'b1;
                match_b = !(p == 0 && k == 7);
                step();
                consume_b = 1'b0;
                match_b = 1'b0;
            end
            checks++;
            if (Count_b !== 8'hC9 || pass_done_b !== 1'b1 || err_cnt_b !== 8'(1 - p)) begin
                failures++;
                $display("FAIL big_end p=%0d: Count=%h pass_done=%b err=%0d required c9 1 %0d", p, Count_b, pass_done_b, err_cnt_b, 1 - p);
            end
            step();
            checks++;
            if (p == 0) begin
                if (Count_b !== 8'd0 || pass_done_b !== 1'b0 || done_b !== 1'b0) begin
                    failures++;
                    $display("FAIL big_marker_width: Count=%h pass_done=%b done=%b required 0 0 0", Count_b, pass_done_b, done_b);
                end
            end else if (done_b !== 1'b1 || converged_b !== 1'b1 || epoch_b !== 8'd2) begin
                failures++;
                $display("FAIL big_done: done=%b conv=%b epoch=%0d required 1 1 2", done_b, converged_b, epoch_b);
            end
        end
    endtask

    initial begin
        step();
        step();
        Rst = 1'b0;
        test_reset();
        load_a();
        run_a(0, 1'b0, 1'b0);            // all correct: converge in one pass
        run_a(1, 1'b0, 1'b0);            // one error per pass: hits MAX_EPOCHS
        run_a(0, 1'b1, 1'b1);            // consume in FETCH, write in PRESENT
        run_a(2, 1'b0, 1'b0);            // table unchanged after ignored write
        test_rst_mid();
        run_a(0, 1'b0, 1'b0);            // replay from sample 0 after reset
        for (int r = 0; r < 4; r++) begin
            run_a(2, 1'($urandom_range(0, 1)), 1'b0);
        end
        test_default_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
